// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. Each accepted start loads two WIDTH-bit
//   operands and processes one bit per clock, LSB first, for WIDTH cycles.
//   The next cycle presents a registered sum/difference, carry and signed
//   overflow, marked by a one-cycle done pulse.
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset
//   start in   1      begin an operation (accepted only when busy=0)
//   a     in   WIDTH  operand A (sampled on the accepted-start edge)
//   b     in   WIDTH  operand B (sampled on the accepted-start edge)
//   cin   in   1      carry-in for add mode (ignored when sub=1)
//   sub   in   1      0: a+b+cin, 1: a-b
//   s     out  WIDTH  registered result
//   c     out  1      registered carry-out (sub mode: 1 = no borrow)
//   ovf   out  1      registered two's-complement overflow
//   busy  out  1      high while bits are being processed
//   done  out  1      one-cycle pulse: s/c/ovf newly valid
//
// Handshake: start is sampled on every rising edge while busy=0 (IDLE or
// DONE); a high sample is the acceptance. There is no back-pressure on the
// result: done is a one-cycle strobe and s/c/ovf hold until the next done.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, a_sh_next;
    logic [WIDTH-1:0] b_sh, b_sh_next;
    logic [WIDTH-1:0] res, res_next;
    logic             carry, carry_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] s_next;
    logic             c_next, ovf_next;
    logic             sum_bit, carry_out;

    // One full-adder slice on the current LSBs.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c     <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            a_sh  <= a_sh_next;
            b_sh  <= b_sh_next;
            res   <= res_next;
            carry <= carry_next;
            cnt   <= cnt_next;
            s     <= s_next;
            c     <= c_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        a_sh_next  = a_sh;
        b_sh_next  = b_sh;
        res_next   = res;
        carry_next = carry;
        cnt_next   = cnt;
        s_next     = s;
        c_next     = c;
        ovf_next   = ovf;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    a_sh_next  = a;
                    // Subtraction is a + ~b + 1.
                    b_sh_next  = sub ? ~b : b;
                    carry_next = sub ? 1'b1 : cin;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                a_sh_next  = a_sh >> 1;
                b_sh_next  = b_sh >> 1;
                // Written as shift-then-set so WIDTH=1 needs no empty slice.
                res_next   = res >> 1;
                res_next[WIDTH-1] = sum_bit;
                carry_next = carry_out;
                cnt_next   = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_next = DONE;
                    s_next     = res_next;
                    c_next     = carry_out;
                    // carry holds the carry into the MSB on the last bit.
                    ovf_next   = carry ^ carry_out;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. Four instances (WIDTH 1, 8, 13,
//   32) share clock, reset and operand buses; each has its own start.
//   Directed vectors carry hand-computed results; the random section uses
//   a wide-integer arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  start_v;
    logic [63:0] a_in, b_in;
    logic        cin_in, sub_in;

    logic [0:0]  s_w1;
    logic [7:0]  s_w8;
    logic [12:0] s_w13;
    logic [31:0] s_w32;
    logic [3:0]  c_v, ovf_v, busy_v, done_v;

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[0:0]), .b(b_in[0:0]),
        .cin(cin_in), .sub(sub_in), .s(s_w1), .c(c_v[0]), .ovf(ovf_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));
    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .sub(sub_in), .s(s_w8), .c(c_v[1]), .ovf(ovf_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));
    serial_adder #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[12:0]), .b(b_in[12:0]),
        .cin(cin_in), .sub(sub_in), .s(s_w13), .c(c_v[2]), .ovf(ovf_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));
    serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in[31:0]), .b(b_in[31:0]),
        .cin(cin_in), .sub(sub_in), .s(s_w32), .c(c_v[3]), .ovf(ovf_v[3]),
        .busy(busy_v[3]), .done(done_v[3]));

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [65:0] exp_q[$];   // {ovf, c, s[63:0]}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int w_of(input int k);
        case (k)
            0:       return 1;
            1:       return 8;
            2:       return 13;
            default: return 32;
        endcase
    endfunction

    function automatic logic [63:0] s_of(input int k);
        case (k)
            0:       return 64'(s_w1);
            1:       return 64'(s_w8);
            2:       return 64'(s_w13);
            default: return 64'(s_w32);
        endcase
    endfunction

    // Reference: plain wide integer arithmetic on w-bit operands.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] a,
                                              input logic [63:0] b, input logic cin,
                                              input logic sub);
        logic [64:0] mask, am, bm, full, sm;
        logic        cy, ov;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        if (sub) begin
            full = am + ((~bm) & mask) + 65'd1;
            ov   = (am[w-1] != bm[w-1]) && (full[w-1] != am[w-1]);
        end else begin
            full = am + bm + {64'd0, cin};
            ov   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        end
        sm = full & mask;
        cy = full[w];
        return {ov, cy, sm[63:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic [65:0] exp,
                         input string tag);
        int          w, lat, busy_n;
        logic [63:0] s_hold;
        logic        s_moved;
        logic [65:0] e;
        w = w_of(k);
        exp_q.push_back(exp);
        s_hold = s_of(k);
        a_in = a; b_in = b; cin_in = cin; sub_in = sub;
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
        // Operands changing after acceptance must not matter.
        a_in   = {$urandom, $urandom};
        b_in   = {$urandom, $urandom};
        cin_in = 1'($urandom_range(0, 1));
        sub_in = 1'($urandom_range(0, 1));
        lat = 1; busy_n = 0; s_moved = 1'b0;
        while (!done_v[k] && lat < w + 10) begin
            if (busy_v[k]) busy_n++;
            if (s_of(k) !== s_hold) s_moved = 1'b1;
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(w + 1));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(w));
        check({tag, " s_hold_in_run"}, 64'(s_moved), 64'd0);
        e = exp_q.pop_front();
        check({tag, " s"}, s_of(k), e[63:0]);
        check({tag, " c"}, 64'(c_v[k]), 64'(e[64]));
        check({tag, " ovf"}, 64'(ovf_v[k]), 64'(e[65]));
        step();
        check({tag, " done_pulse"}, 64'(done_v[k]), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          k, done_n;
        logic [63:0] ra, rb;
        logic        rc, rs;

        rst = 1'b1; start_v = '0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        step();
        step();
        check("reset s", 64'(s_w8), 64'd0);
        check("reset c", 64'(c_v[1]), 64'd0);
        check("reset ovf", 64'(ovf_v[1]), 64'd0);
        check("reset busy", 64'(busy_v), 64'd0);
        check("reset done", 64'(done_v), 64'd0);
        rst = 1'b0;

        // Accepted on the first edge after reset release.
        do_op(1, 64'hFF, 64'h01, 1'b0, 1'b0, {1'b0, 1'b1, 64'h00}, "ff_plus_1");
        do_op(1, 64'h7F, 64'h01, 1'b0, 1'b0, {1'b1, 1'b0, 64'h80}, "7f_plus_1");
        do_op(1, 64'h05, 64'h07, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFE}, "5_minus_7");
        do_op(1, 64'h40, 64'h22, 1'b1, 1'b0, {1'b0, 1'b0, 64'h63}, "40_plus_22_cin");
        do_op(1, 64'h80, 64'h01, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7F}, "80_minus_1");

        // WIDTH=1 half adder.
        do_op(0, 64'h0, 64'h0, 1'b0, 1'b0, {1'b0, 1'b0, 64'h0}, "w1_00");
        do_op(0, 64'h0, 64'h1, 1'b0, 1'b0, {1'b0, 1'b0, 64'h1}, "w1_01");
        do_op(0, 64'h1, 64'h0, 1'b0, 1'b0, {1'b0, 1'b0, 64'h1}, "w1_10");
        do_op(0, 64'h1, 64'h1, 1'b0, 1'b0, {1'b1, 1'b1, 64'h0}, "w1_11");

        // Starts during RUN are ignored; start in DONE chains immediately.
        a_in = 64'h12; b_in = 64'h34; cin_in = 1'b0; sub_in = 1'b0;
        start_v[1] = 1'b1;
        step();                       // RUN cycle 1
        start_v[1] = 1'b0;
        step();                       // RUN cycle 2
        step();                       // RUN cycle 3
        start_v[1] = 1'b1; a_in = 64'hFF; b_in = 64'hFF;
        step();                       // RUN cycle 4
        start_v[1] = 1'b0;
        check("ignore busy", 64'(busy_v[1]), 64'd1);
        step();                       // RUN cycle 5
        start_v[1] = 1'b1; a_in = 64'h80; b_in = 64'h80; sub_in = 1'b1;
        step();                       // RUN cycle 6
        start_v[1] = 1'b0;
        done_n = 0;
        step();
        if (done_v[1]) done_n++;
        step();                       // RUN cycle 8
        if (done_v[1]) done_n++;
        check("ignore early_done", 64'(done_n), 64'd0);
        step();                       // DONE
        check("ignore done", 64'(done_v[1]), 64'd1);
        check("ignore s", 64'(s_w8), 64'h46);
        check("ignore c", 64'(c_v[1]), 64'd0);
        check("ignore ovf", 64'(ovf_v[1]), 64'd0);
        start_v[1] = 1'b1; a_in = 64'h01; b_in = 64'h02; cin_in = 1'b0; sub_in = 1'b0;
        step();                       // next RUN cycle 1
        check("chain busy", 64'(busy_v[1]), 64'd1);
        check("chain done", 64'(done_v[1]), 64'd0);
        start_v[1] = 1'b0;
        done_n = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (done_v[1]) done_n++;
        end
        check("chain early_done", 64'(done_n), 64'd0);
        step();
        check("chain done2", 64'(done_v[1]), 64'd1);
        check("chain s", 64'(s_w8), 64'h03);

        // Reset in RUN cycle 4 aborts.
        a_in = 64'h55; b_in = 64'h11; sub_in = 1'b0;
        start_v[1] = 1'b1;
        step();                       // RUN cycle 1
        start_v[1] = 1'b0;
        step();
        step();
        step();                       // RUN cycle 4
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", 64'(busy_v[1]), 64'd0);
        check("abort done", 64'(done_v[1]), 64'd0);
        check("abort s", 64'(s_w8), 64'd0);
        check("abort c", 64'(c_v[1]), 64'd0);
        check("abort ovf", 64'(ovf_v[1]), 64'd0);
        done_n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done_v[1]) done_n++;
        end
        check("abort no_done", 64'(done_n), 64'd0);
        do_op(1, 64'h55, 64'h11, 1'b0, 1'b0, {1'b0, 1'b0, 64'h66}, "after_abort");

        // Reset beats start in the same cycle.
        rst = 1'b1; start_v[1] = 1'b1;
        step();
        rst = 1'b0; start_v[1] = 1'b0;
        check("rst_vs_start busy", 64'(busy_v[1]), 64'd0);

        // Random widths and operands against the reference.
        for (int i = 0; i < 24; i++) begin
            k  = $urandom_range(0, 3);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            do_op(k, ra, rb, rc, rs, ref_model(w_of(k), ra, rb, rc, rs), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
